// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sequencer sharing one 32-bit add/sub unit between two requesters.
// One op in flight: IDLE accepts, EXEC drives the unit, RESP holds the registered result.
module addsub_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p0_valid,
  output logic             p0_ready,
  input  logic             p0_sub,
  input  logic [WIDTH-1:0] p0_a,
  input  logic [WIDTH-1:0] p0_b,
  input  logic             p1_valid,
  output logic             p1_ready,
  input  logic             p1_sub,
  input  logic [WIDTH-1:0] p1_a,
  input  logic [WIDTH-1:0] p1_b,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  output logic             unit_sub,
  input  logic [WIDTH-1:0] unit_result,
  input  logic             unit_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cout
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           r_state;
  logic             r_last_id;
  logic             r_id;
  logic             r_sub;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             w_req;
  logic             w_sel;
  logic             w_idle;
  assign w_req  = p0_valid || p1_valid;
  // a tie goes to the port that did not win last time
  assign w_sel  = (p0_valid && p1_valid) ? ~r_last_id : p1_valid;
  assign w_idle = rst_n && (r_state == IDLE) && w_req;
  assign p0_ready = w_idle && !w_sel;
  assign p1_ready = w_idle && w_sel;
  assign unit_a   = r_a;
  assign unit_b   = r_b;
  assign unit_sub = r_sub;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last_id <= 1'b1;
      r_id      <= 1'b0;
      r_sub     <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_req) begin
          r_a       <= w_sel ? p1_a : p0_a;
          r_b       <= w_sel ? p1_b : p0_b;
          r_sub     <= w_sel ? p1_sub : p0_sub;
          r_id      <= w_sel;
          r_last_id <= w_sel;
          r_state   <= EXEC;
        end
        EXEC: begin
          rsp_data  <= unit_result;
          rsp_cout  <= unit_cout;
          rsp_id    <= r_id;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: table vectors, hand-written corner sequences and a randomized run
// against a cycle-level reference model; the shared add/sub unit is modelled here.
module tb_addsub_arbiter;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        p0_valid = 0, p0_sub = 0, p1_valid = 0, p1_sub = 0;
  logic [31:0] p0_a = 0, p0_b = 0, p1_a = 0, p1_b = 0;
  logic        p0_ready, p1_ready;
  logic [31:0] unit_a, unit_b, unit_result, rsp_data;
  logic        unit_sub, unit_cout, rsp_valid, rsp_id, rsp_cout;
  logic        rsp_ready = 1;
  int          n_chk = 0, n_err = 0;
  logic        tb_last = 1;

  addsub_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_sub(p0_sub), .p0_a(p0_a), .p0_b(p0_b),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_sub(p1_sub), .p1_a(p1_a), .p1_b(p1_b),
    .unit_a(unit_a), .unit_b(unit_b), .unit_sub(unit_sub),
    .unit_result(unit_result), .unit_cout(unit_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout)
  );

  always #5 clk = ~clk;

  // shared adder/subtractor: subtract as a + ~b + 1 so carry-out means "no borrow"
  assign {unit_cout, unit_result} = unit_sub ? {1'b0, unit_a} + {1'b0, ~unit_b} + 33'd1
                                             : {1'b0, unit_a} + {1'b0, unit_b};

  typedef struct {
    logic        port;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_d;
    logic        exp_c;
  } vec_t;

  function automatic logic [32:0] ref_op(input logic sub, input logic [31:0] a, input logic [31:0] b);
    longint unsigned s;
    if (sub) return {a >= b, a - b};
    s = longint'(a) + longint'(b);
    return {s >= 64'h1_0000_0000, s[31:0]};
  endfunction

  function automatic logic [31:0] rnd();
    int k = $urandom_range(3);
    return k == 0 ? 32'h0 : k == 1 ? 32'hFFFF_FFFF : $urandom;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic port, input logic sub, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic exp_c);
    int k;
    @(negedge clk);
    rsp_ready = 1;
    if (port) begin p1_valid = 1; p1_sub = sub; p1_a = a; p1_b = b; end
    else begin p0_valid = 1; p0_sub = sub; p0_a = a; p0_b = b; end
    #1;
    for (k = 0; k < 8 && !(port ? p1_ready : p0_ready); k++) begin @(negedge clk); #1; end
    chk("op_grant", port ? p1_ready : p0_ready, 1);
    @(negedge clk);
    p0_valid = 0; p1_valid = 0;
    #1;
    tb_last = port;
    chk("op_exec_rsp_valid", rsp_valid, 0);
    chk("op_exec_unit", {unit_sub, unit_a, unit_b}, {sub, a, b});
    @(negedge clk); #1;
    chk("op_rsp_valid", rsp_valid, 1);
    chk("op_rsp", {rsp_id, rsp_cout, rsp_data}, {port, exp_c, exp_d});
  endtask

  vec_t        vecs[8];
  logic [32:0] e_rsp;
  logic        e_id, e0, e1, g, drop0, drop1;
  logic [33:0] held;
  int          ph, k;

  initial begin
    vecs[0] = '{0, 1, 32'd10, 32'd3, 32'd7, 1};
    vecs[1] = '{0, 1, 32'd5, 32'd0, 32'd5, 1};
    vecs[2] = '{1, 1, 32'd3, 32'd5, 32'hFFFF_FFFE, 0};
    vecs[3] = '{0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1};
    vecs[4] = '{1, 0, 32'd1, 32'd2, 32'd3, 0};
    vecs[5] = '{1, 1, 32'd0, 32'd0, 32'd0, 1};
    vecs[6] = '{0, 0, 32'h8000_0000, 32'h8000_0000, 32'd0, 1};
    vecs[7] = '{1, 0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 0};

    // reset with both requesters active
    p0_valid = 1; p0_sub = 1; p0_a = 10; p0_b = 3;
    p1_valid = 1; p1_sub = 0; p1_a = 1; p1_b = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", {p0_ready, p1_ready}, 0);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_data}, 0);
    chk("rst_unit", {unit_sub, unit_a, unit_b}, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_first_tie", {p0_ready, p1_ready}, 2'b10);
    @(negedge clk);
    p0_valid = 0; p1_valid = 0;
    #1;
    chk("rst_exec", {rsp_valid, unit_sub, unit_a, unit_b}, {1'b0, 1'b1, 32'd10, 32'd3});
    @(negedge clk); #1;
    chk("rst_sub_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_data}, {1'b1, 1'b0, 1'b1, 32'd7});
    tb_last = 0;

    for (int i = 0; i < 8; i++) run_op(vecs[i].port, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_c);

    // contention: both ports valid continuously, grants must alternate
    @(negedge clk);
    p0_valid = 1; p0_sub = $urandom_range(1); p0_a = rnd(); p0_b = rnd();
    p1_valid = 1; p1_sub = $urandom_range(1); p1_a = rnd(); p1_b = rnd();
    for (int n = 0; n < 8; n++) begin
      #1;
      for (k = 0; k < 8 && !(p0_ready || p1_ready); k++) begin @(negedge clk); #1; end
      chk("cont_grant", {p0_ready, p1_ready}, tb_last ? 2'b10 : 2'b01);
      g = p1_ready;
      e_rsp = g ? ref_op(p1_sub, p1_a, p1_b) : ref_op(p0_sub, p0_a, p0_b);
      tb_last = g;
      @(negedge clk);
      if (g) begin p1_sub = $urandom_range(1); p1_a = rnd(); p1_b = rnd(); end
      else begin p0_sub = $urandom_range(1); p0_a = rnd(); p0_b = rnd(); end
      @(negedge clk); #1;
      chk("cont_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_data}, {1'b1, g, e_rsp});
      @(negedge clk);
    end
    p0_valid = 0; p1_valid = 0;

    // backpressure
    @(negedge clk);
    rsp_ready = 0;
    p0_valid = 1; p0_sub = 0; p0_a = 100; p0_b = 58;
    #1;
    for (k = 0; k < 8 && !p0_ready; k++) begin @(negedge clk); #1; end
    chk("bp_grant", p0_ready, 1);
    @(negedge clk);
    p0_valid = 0; p1_valid = 1; p1_sub = 0; p1_a = 7; p1_b = 7;
    @(negedge clk); #1;
    chk("bp_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_data}, {1'b1, 1'b0, 1'b0, 32'd158});
    held = {rsp_valid, rsp_id, rsp_cout, rsp_data[30:0]};
    for (int n = 0; n < 5; n++) begin
      @(negedge clk); #1;
      chk("bp_hold", {rsp_valid, rsp_id, rsp_cout, rsp_data}, {1'b1, 1'b0, 1'b0, 32'd158});
      chk("bp_no_ready", {p0_ready, p1_ready}, 0);
    end
    rsp_ready = 1;
    @(negedge clk); #1;
    chk("bp_release", {rsp_valid, p1_ready}, 2'b01);
    p1_valid = 0;

    // reset during EXEC of a port 1 op
    @(negedge clk);
    p1_valid = 1; p1_sub = 1; p1_a = 9; p1_b = 4;
    #1;
    for (k = 0; k < 8 && !p1_ready; k++) begin @(negedge clk); #1; end
    chk("mid_grant", p1_ready, 1);
    @(negedge clk);
    p1_valid = 0;
    #1;
    rst_n = 0;
    #2;
    chk("mid_rst_state", {rsp_valid, unit_sub, unit_a, unit_b, p0_ready, p1_ready}, 0);
    @(negedge clk);
    rst_n = 1;
    e0 = 0;
    for (int n = 0; n < 4; n++) begin @(negedge clk); #1; e0 = e0 | rsp_valid; end
    chk("mid_no_rsp", e0, 0);
    tb_last = 1;
    run_op(0, 0, 32'd1, 32'd2, 32'd3, 0);

    // randomized traffic against the reference model
    @(negedge clk);
    ph = 0; drop0 = 0; drop1 = 0;
    for (int n = 0; n < 400; n++) begin
      if (n > 0) @(negedge clk);
      if (drop0) p0_valid = 0;
      if (drop1) p1_valid = 0;
      drop0 = 0; drop1 = 0;
      if (!p0_valid && $urandom_range(2) == 0) begin p0_valid = 1; p0_sub = $urandom_range(1); p0_a = rnd(); p0_b = rnd(); end
      if (!p1_valid && $urandom_range(2) == 0) begin p1_valid = 1; p1_sub = $urandom_range(1); p1_a = rnd(); p1_b = rnd(); end
      rsp_ready = $urandom_range(1);
      #1;
      e0 = ph == 0 && p0_valid && (!p1_valid || tb_last);
      e1 = ph == 0 && p1_valid && (!p0_valid || !tb_last);
      chk("rnd_ready", {p0_ready, p1_ready}, {e0, e1});
      chk("rnd_rsp_valid", rsp_valid, ph == 2);
      if (ph == 2) chk("rnd_rsp", {rsp_id, rsp_cout, rsp_data}, {e_id, e_rsp});
      if (e0 || e1) begin
        tb_last = e1; e_id = e1;
        e_rsp = e1 ? ref_op(p1_sub, p1_a, p1_b) : ref_op(p0_sub, p0_a, p0_b);
        drop0 = e0; drop1 = e1; ph = 1;
      end else if (ph == 1) ph = 2;
      else if (ph == 2 && rsp_ready) ph = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
